// File: rtl/vga_frame_engine.sv
// VGA timing generator with configurable porches, frame counter and a
// frame-aligned light-gun trigger sequencer (shot pulse + flash window).
module vga_frame_engine #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int SYNC_POL     = 0,
  parameter int COORD_W      = 10,
  parameter int FRAME_W      = 16,
  parameter int FLASH_FRAMES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  input  logic               trigger,
  output logic               hsync,
  output logic               vsync,
  output logic               valid,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count,
  output logic               shot,
  output logic               flash_active
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CNT_W   = $clog2(FLASH_FRAMES + 1);

  localparam logic [COORD_W-1:0] H_LAST  = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST  = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT   = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT   = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_BEG  = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_LAST = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_BEG  = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_LAST = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic               POL     = (SYNC_POL != 0);
  localparam logic [CNT_W-1:0]   FL_INIT = CNT_W'(FLASH_FRAMES);
  localparam logic [CNT_W-1:0]   FL_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    FLASH
  } tstate_t;

  logic [COORD_W-1:0] h;
  logic [COORD_W-1:0] v;
  logic               h_wrap;
  logic               v_wrap;
  logic               at_origin;
  logic               fs_now;
  logic               hs_win;
  logic               vs_win;
  logic               act;

  assign h_wrap    = (h == H_LAST);
  assign v_wrap    = (v == V_LAST);
  assign at_origin = (h == '0) && (v == '0);
  assign fs_now    = ce && at_origin;
  assign hs_win    = (h >= HS_BEG) && (h <= HS_LAST);
  assign vs_win    = (v >= VS_BEG) && (v <= VS_LAST);
  assign act       = (h < H_ACT) && (v < V_ACT);

  always_ff @(posedge clk) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (ce) begin
      h <= h_wrap ? '0 : h + COORD_W'(1);
      if (h_wrap)
        v <= v_wrap ? '0 : v + COORD_W'(1);
    end
  end

  // Decode registered so every output describes the same pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      col         <= '0;
      row         <= '0;
      valid       <= 1'b0;
      hsync       <= ~POL;
      vsync       <= ~POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (ce) begin
        col         <= h;
        row         <= v;
        valid       <= act;
        hsync       <= hs_win ? POL : ~POL;
        vsync       <= vs_win ? POL : ~POL;
        line_start  <= (h == '0);
        frame_start <= at_origin;
        if (at_origin)
          frame_count <= frame_count + FRAME_W'(1);
      end
    end
  end

  logic sync1;
  logic sync2;
  logic prev;
  logic edge_det;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      prev     <= 1'b0;
      edge_det <= 1'b0;
    end else begin
      sync1    <= trigger;
      sync2    <= sync1;
      prev     <= sync2;
      edge_det <= sync2 & ~prev;
    end
  end

  tstate_t          state;
  tstate_t          state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             shot_nxt;
  logic             flash_nxt;

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (edge_det) state_nxt = PENDING;
      PENDING: if (fs_now) state_nxt = FLASH;
      FLASH:   if (fs_now && cnt == FL_ONE) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shot_nxt  = 1'b0;
    flash_nxt = flash_active;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: flash_nxt = 1'b0;
      PENDING: begin
        if (fs_now) begin
          shot_nxt  = 1'b1;
          flash_nxt = 1'b1;
          cnt_nxt   = FL_INIT;
        end
      end
      FLASH: begin
        if (fs_now) begin
          cnt_nxt = cnt - FL_ONE;
          if (cnt == FL_ONE)
            flash_nxt = 1'b0;
        end
      end
      default: flash_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shot         <= 1'b0;
      flash_active <= 1'b0;
      cnt          <= '0;
    end else begin
      shot         <= shot_nxt;
      flash_active <= flash_nxt;
      cnt          <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_vga_frame_engine.sv
// Bench for vga_frame_engine: small 14x7 timing, frame_start scoreboard
// plus per-cycle sync/coordinate checks on two polarity variants.
module tb_vga_frame_engine;

  localparam int CW = 4;
  localparam int FW = 3;

  logic          clk;
  logic          reset;
  logic          ce;
  logic          trigger;
  logic          hsync, vsync, valid;
  logic [CW-1:0] col, row;
  logic          line_start, frame_start;
  logic [FW-1:0] frame_count;
  logic          shot, flash_active;

  logic          p_hsync, p_vsync, p_valid;
  logic [CW-1:0] p_col, p_row;
  logic          p_line_start, p_frame_start;
  logic [FW-1:0] p_frame_count;
  logic          p_shot, p_flash;

  vga_frame_engine #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(0), .COORD_W(CW), .FRAME_W(FW), .FLASH_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .trigger(trigger),
    .hsync(hsync), .vsync(vsync), .valid(valid),
    .col(col), .row(row),
    .line_start(line_start), .frame_start(frame_start),
    .frame_count(frame_count), .shot(shot),
    .flash_active(flash_active)
  );

  vga_frame_engine #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1), .COORD_W(CW), .FRAME_W(FW), .FLASH_FRAMES(2)
  ) dut_pol (
    .clk(clk), .reset(reset), .ce(ce), .trigger(trigger),
    .hsync(p_hsync), .vsync(p_vsync), .valid(p_valid),
    .col(p_col), .row(p_row),
    .line_start(p_line_start), .frame_start(p_frame_start),
    .frame_count(p_frame_count), .shot(p_shot),
    .flash_active(p_flash)
  );

  typedef struct {
    int cyc;
    int fc;
    int shot;
    int flash;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic ce_q = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d, t=%0t)",
               name, act, exp, cyc, $time);
    end
  endtask

  task automatic push(input int c, input int f, input int s, input int fl);
    exp_t e;
    e.cyc = c;
    e.fc = f;
    e.shot = s;
    e.flash = fl;
    sbq.push_back(e);
  endtask

  task automatic drain(input string name);
    chk(name, sbq.size(), 0);
    sbq.delete();
  endtask

  // Assert reset at the current negedge, check the state one clk later.
  task automatic do_reset();
    reset = 1'b1;
    ce = 1'b1;
    @(negedge clk);
    chk("rst_col", col, 0);
    chk("rst_row", row, 0);
    chk("rst_valid", valid, 0);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_p_hsync", p_hsync, 0);
    chk("rst_p_vsync", p_vsync, 0);
    chk("rst_line_start", line_start, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_shot", shot, 0);
    chk("rst_flash", flash_active, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  always @(posedge clk) begin
    if (reset) cyc = 0;
    else cyc++;
    ce_q = ce;
  end

  int   last_col = 0;
  int   last_row = 0;
  int   last_fc = 0;
  logic last_flash = 1'b0;

  always @(negedge clk) begin
    int   ec;
    int   er;
    exp_t e;
    if (!reset && cyc >= 1) begin
      chk("valid", valid, int'(col < 8 && row < 4));
      chk("hsync", hsync, int'(!(col >= 10 && col <= 11)));
      chk("vsync", vsync, int'(row != 5));
      chk("p_hsync", p_hsync, int'(p_col >= 10 && p_col <= 11));
      chk("p_vsync", p_vsync, int'(p_row == 5));
      chk("p_col", p_col, col);
      if (!ce_q) begin
        chk("ls_hold", line_start, 0);
        chk("fs_hold", frame_start, 0);
        chk("shot_hold", shot, 0);
      end else begin
        chk("line_start", line_start, int'(col == 0));
        chk("frame_start", frame_start, int'(col == 0 && row == 0));
      end
      if (cyc >= 2) begin
        ec = last_col;
        er = last_row;
        if (ce_q) begin
          ec = (last_col == 13) ? 0 : last_col + 1;
          if (last_col == 13) er = (last_row == 6) ? 0 : last_row + 1;
        end
        chk("col_step", col, ec);
        chk("row_step", row, er);
        if (!frame_start) begin
          chk("fc_hold", frame_count, last_fc);
          chk("flash_hold", flash_active, last_flash);
          chk("shot_off", shot, 0);
        end
      end
      if (frame_start) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fs_unexpected: frame_start at cyc %0d, none due",
                   cyc);
        end else begin
          e = sbq.pop_front();
          chk("fs_cyc", cyc, e.cyc);
          chk("fs_count", frame_count, e.fc);
          chk("fs_shot", shot, e.shot);
          chk("fs_flash", flash_active, e.flash);
        end
      end
    end
    last_col = col;
    last_row = row;
    last_fc = frame_count;
    last_flash = flash_active;
  end

  initial begin
    reset = 1'b1;
    ce = 1'b1;
    trigger = 1'b0;
    @(negedge clk);

    // Free-running frames, frame_count wraps through 0.
    do_reset();
    for (int k = 0; k < 9; k++) push(1 + 98 * k, (k + 1) % 8, 0, 0);
    repeat (800) @(negedge clk);
    drain("drain_free_run");

    // Half-rate pixel enable doubles the frame period.
    do_reset();
    push(1, 1, 0, 0);
    push(197, 2, 0, 0);
    push(393, 3, 0, 0);
    repeat (400) begin
      @(negedge clk);
      ce = ~ce;
    end
    ce = 1'b1;
    drain("drain_ce_half");

    // Shot at next frame_start, two-frame flash, retrigger ignored.
    do_reset();
    push(1, 1, 0, 0);
    push(99, 2, 1, 1);
    push(197, 3, 0, 1);
    push(295, 4, 0, 0);
    push(393, 5, 0, 0);
    repeat (40) @(negedge clk);
    trigger = 1'b1;
    repeat (3) @(negedge clk);
    trigger = 1'b0;
    repeat (107) @(negedge clk);
    trigger = 1'b1;
    repeat (3) @(negedge clk);
    trigger = 1'b0;
    repeat (247) @(negedge clk);
    drain("drain_trigger");

    // Reset while flashing at row 2 aborts the sequence.
    do_reset();
    push(1, 1, 0, 0);
    push(99, 2, 1, 1);
    repeat (40) @(negedge clk);
    trigger = 1'b1;
    repeat (3) @(negedge clk);
    trigger = 1'b0;
    repeat (87) @(negedge clk);
    chk("pre_rst_flash", flash_active, 1);
    chk("pre_rst_row", row, 2);
    drain("drain_pre_reset");
    do_reset();
    push(1, 1, 0, 0);
    push(99, 2, 0, 0);
    push(197, 3, 0, 0);
    repeat (210) @(negedge clk);
    drain("drain_post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
